seq_sort_calc: RTL and testbench

SEQ_SORT_CALC -- requirements
Module: seq_sort_calc

---
 rtl/seq_sort_calc.sv | 173 +++++++++++++++++
 tb/tb_seq_sort_calc.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_sort_calc.sv
// seq_sort_calc: collects six 4-bit operands into a sorted buffer, conditions
// them (normalize or smooth), then evaluates one of two equations.
module seq_sort_calc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_n,
  input  logic [2:0] opt,
  input  logic       equ,
  output logic       out_valid,
  output logic [9:0] out_n
);

  localparam int unsigned NUM_OPS = 6;
  localparam int unsigned VAL_W   = 5;
  localparam int unsigned OUT_W   = 10;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_IN   = 3'd1;
  localparam logic [2:0] S_PROC = 3'd2;
  localparam logic [2:0] S_CALC = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [2:0]              opt_q, opt_d;
  logic                    equ_q, equ_d;
  logic signed [VAL_W-1:0] sort_q [NUM_OPS];
  logic signed [VAL_W-1:0] sort_d [NUM_OPS];
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_n_q, out_n_d;

  // Insertion datapath
  logic                    sgn_c;
  logic                    desc_c;
  logic [2:0]              ins_k_c;
  logic signed [VAL_W-1:0] ext_c;
  logic [NUM_OPS-1:0]      shift_c;
  logic signed [VAL_W-1:0] ins_c [NUM_OPS];

  // Conditioning datapath
  logic signed [6:0]       sm_sum_c;
  logic signed [6:0]       sm_quo_c;
  logic signed [VAL_W-1:0] proc_c [NUM_OPS];

  // Equation datapath
  logic signed [15:0]      c0_c, c1_c, c3_c, c4_c, c5_c;
  logic signed [15:0]      sum_c, prod_c, quo_c, t_c;
  logic signed [10:0]      t11_c, abs_c;
  logic [OUT_W-1:0]        calc_c;

  // Extend the incoming operand and insert it into the sorted buffer
  always_comb begin
    sgn_c   = (state_q == S_IDLE) ? opt[0] : opt_q[0];
    desc_c  = (state_q == S_IDLE) ? opt[1] : opt_q[1];
    ins_k_c = (state_q == S_IDLE) ? 3'd0 : cnt_q;
    ext_c   = sgn_c ? {in_n[3], in_n} : {1'b0, in_n};
    shift_c = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (3'(i) >= ins_k_c)  shift_c[i] = 1'b1;
      else if (desc_c)       shift_c[i] = (sort_q[i] < ext_c);
      else                   shift_c[i] = (sort_q[i] > ext_c);
    end
    ins_c[0] = shift_c[0] ? ext_c : sort_q[0];
    for (int i = 1; i < NUM_OPS; i++) begin
      if (!shift_c[i])        ins_c[i] = sort_q[i];
      else if (!shift_c[i-1]) ins_c[i] = ext_c;
      else                    ins_c[i] = sort_q[i-1];
    end
  end

  // Normalize against n0, or smooth using the already-updated predecessor
  always_comb begin
    sm_sum_c  = '0;
    sm_quo_c  = '0;
    proc_c[0] = opt_q[2] ? sort_q[0] : '0;
    for (int i = 1; i < NUM_OPS; i++) begin
      sm_sum_c  = 7'(proc_c[i-1]) + 7'(proc_c[i-1]) + 7'(sort_q[i]);
      sm_quo_c  = sm_sum_c / 7'sd3;
      proc_c[i] = opt_q[2] ? 5'(sm_quo_c) : (sort_q[i] - sort_q[0]);
    end
  end

  // Evaluate the selected equation on the conditioned buffer
  always_comb begin
    c0_c   = 16'(sort_q[0]);
    c1_c   = 16'(sort_q[1]);
    c3_c   = 16'(sort_q[3]);
    c4_c   = 16'(sort_q[4]);
    c5_c   = 16'(sort_q[5]);
    sum_c  = c3_c + (c4_c * 16'sd4);
    prod_c = sum_c * c5_c;
    quo_c  = prod_c / 16'sd3;
    t_c    = (c5_c * c1_c) - (c5_c * c0_c);
    t11_c  = 11'(t_c);
    abs_c  = t11_c[10] ? -t11_c : t11_c;
    calc_c = equ_q ? 10'(abs_c) : 10'(quo_c);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      opt_q       <= '0;
      equ_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_n_q     <= '0;
      for (int i = 0; i < NUM_OPS; i++) sort_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opt_q       <= opt_d;
      equ_q       <= equ_d;
      out_valid_q <= out_valid_d;
      out_n_q     <= out_n_d;
      for (int i = 0; i < NUM_OPS; i++) sort_q[i] <= sort_d[i];
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opt_d       = opt_q;
    equ_d       = equ_q;
    sort_d      = sort_q;
    out_valid_d = 1'b0;
    out_n_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opt_d   = opt;
          equ_d   = equ;
          sort_d  = ins_c;
          cnt_d   = 3'd1;
          state_d = S_IN;
        end
      end
      S_IN: begin
        if (in_valid) begin
          sort_d = ins_c;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'(NUM_OPS - 1)) state_d = S_PROC;
        end else begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_PROC: begin
        sort_d  = proc_c;
        state_d = S_CALC;
      end
      S_CALC: begin
        out_valid_d = 1'b1;
        out_n_d     = calc_c;
        state_d     = S_OUT;
      end
      S_OUT: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_n     = out_n_q;

endmodule

// File: tb/tb_seq_sort_calc.sv
// Self-checking bench for seq_sort_calc: directed cases plus randomized
// transactions compared against an arithmetic reference model.
module tb_seq_sort_calc;

  typedef logic [3:0] ops_t [6];
  typedef struct {
    int         due;
    logic [9:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_n = '0;
  logic [2:0] opt = '0;
  logic       equ = 1'b0;
  logic       out_valid;
  logic [9:0] out_n;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;
  exp_t exp_q [$];

  seq_sort_calc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_n      (in_n),
    .opt       (opt),
    .equ       (equ),
    .out_valid (out_valid),
    .out_n     (out_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point for every check in the bench
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int wrap5(input int x);
    int y;
    y = x & 31;
    if (y >= 16) y = y - 32;
    return y;
  endfunction

  // Reference: extend, sort, condition, evaluate -- straight from the rules
  function automatic logic [9:0] ref_model(input ops_t ops, input logic [2:0] o, input logic e);
    int v [6];
    int tmp;
    int r;
    int base;
    logic [31:0] rb;
    for (int i = 0; i < 6; i++) begin
      v[i] = int'(ops[i]);
      if (o[0] && v[i] >= 8) v[i] = v[i] - 16;
    end
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5 - i; j++)
        if (o[1] ? (v[j] < v[j+1]) : (v[j] > v[j+1])) begin
          tmp = v[j]; v[j] = v[j+1]; v[j+1] = tmp;
        end
    if (!o[2]) begin
      base = v[0];
      for (int i = 1; i < 6; i++) v[i] = wrap5(v[i] - base);
      v[0] = 0;
    end else begin
      for (int i = 1; i < 6; i++) v[i] = wrap5((2 * v[i-1] + v[i]) / 3);
    end
    if (!e) begin
      r = ((v[3] + 4 * v[4]) * v[5]) / 3;
    end else begin
      r = (v[5] * v[1] - v[5] * v[0]) & 'h7FF;
      if (r >= 1024) r = r - 2048;
      if (r < 0) r = -r;
    end
    rb = r;
    return rb[9:0];
  endfunction

  // Every cycle: out_valid/out_n must match the expected pulse schedule
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_out_n", 32'(out_n), 32'd0);
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check("pulse_valid", 32'(out_valid), 32'd1);
      check("pulse_out_n", 32'(out_n), 32'(exp_q[0].val));
      void'(exp_q.pop_front());
    end else begin
      check("quiet_valid", 32'(out_valid), 32'd0);
      check("quiet_out_n", 32'(out_n), 32'd0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_n     = 4'($urandom);
    end
  endtask

  // Drive the first n operands; in_valid is left high after the last one
  task automatic send_partial(input ops_t ops, input logic [2:0] o, input logic e, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_n     = ops[i];
      opt      = (i == 0) ? o : 3'($urandom);
      equ      = (i == 0) ? e : 1'($urandom);
    end
  endtask

  // Full transaction; spur keeps in_valid toggling through PROC/CALC/OUT
  task automatic send(input ops_t ops, input logic [2:0] o, input logic e,
                      input logic [9:0] exp, input logic spur);
    send_partial(ops, o, e, 6);
    exp_q.push_back('{due: cyc + 3, val: exp});
    repeat (3) begin
      @(posedge clk); #1;
      in_valid = spur;
      in_n     = 4'($urandom);
      opt      = 3'($urandom);
      equ      = 1'($urandom);
    end
  endtask

  task automatic reset_pulse(input string tag);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_n"}, 32'(out_n), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ops_t d25, d26, d27, r;
    logic [2:0] ro;
    logic       re;
    d25 = '{4'd3, 4'd9, 4'd1, 4'd7, 4'd0, 4'd5};
    d26 = '{4'hF, 4'h2, 4'h8, 4'h7, 4'h0, 4'h3};
    d27 = '{4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15};

    repeat (3) @(posedge clk);
    #1;
    check("init_valid", 32'(out_valid), 32'd0);
    check("init_out_n", 32'(out_n), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Directed values
    send(d25, 3'b000, 1'b0, 10'd99, 1'b0);  idle(3);
    send(d25, 3'b000, 1'b1, 10'd9, 1'b1);   idle(2);
    send(d26, 3'b011, 1'b1, 10'd60, 1'b0);  idle(1);
    send(d26, 3'b011, 1'b0, 10'd195, 1'b1); idle(2);
    send(d27, 3'b100, 1'b0, 10'd84, 1'b1);  idle(2);

    // Back-to-back with in_valid held during PROC/CALC/OUT
    send(d25, 3'b000, 1'b0, 10'd99, 1'b1);
    send(d26, 3'b011, 1'b1, 10'd60, 1'b1);
    idle(3);

    // Reset while out_valid is high, then a clean transaction
    send(d25, 3'b000, 1'b0, 10'd99, 1'b0);
    reset_pulse("rst_out");
    send(d26, 3'b011, 1'b1, 10'd60, 1'b0);  idle(2);

    // Reset after the third operand
    send_partial(d25, 3'b000, 1'b0, 3);
    reset_pulse("rst_in");
    send(d26, 3'b011, 1'b1, 10'd60, 1'b0);  idle(2);

    // in_valid drops after four operands: no pulse, then recovery
    send_partial(d27, 3'b100, 1'b0, 4);
    idle(8);
    send(d27, 3'b100, 1'b0, 10'd84, 1'b0);  idle(2);

    // Randomized transactions
    for (int k = 0; k < 1000; k++) begin
      for (int i = 0; i < 6; i++) r[i] = 4'($urandom);
      ro = 3'($urandom);
      re = 1'($urandom);
      send(r, ro, re, ref_model(r, ro, re), 1'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    idle(6);
    check("pending_pulses", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
